// File: rtl/imm_encoder_pkg.sv
// rtl/imm_encoder_pkg.sv - shared encodings, state enum and opcode constants for imm_encoder
package imm_encoder_pkg;

  // Must stay identical to the immediate extender's ImmSrc encoding.
  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_X = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_FULL = 2'b10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // True when v[31:lsb] are all copies of the sign bit.
  function automatic logic sext_fits(input logic [31:0] v, input int unsigned lsb);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> lsb);
    return (hi == 32'h0) || (hi == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// rtl/imm_encoder_if.sv - loader-side field stream and instruction-memory write port
interface imm_encoder_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_imm_src;
  logic [31:0]       in_imm;
  logic [6:0]        in_opcode;
  logic [2:0]        in_funct3;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_imm_src, in_imm, in_opcode, in_funct3, in_rd, in_rs1, in_rs2,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_imm_src, in_imm, in_opcode, in_funct3, in_rd, in_rs1, in_rs2,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imm_encoder_pack.sv
// rtl/imm_encoder_pack.sv - combinational I/S/B immediate scatter with range check
module imm_pack
  import imm_encoder_pkg::*;
(
  input  logic [1:0]  src,
  input  logic [31:0] imm,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = 32'h0;
    legal = 1'b0;
    case (imm_src_e'(src))
      IMM_I: begin
        legal = sext_fits(imm, 11);
        word  = {imm[11:0], rs1, funct3, rd, opcode};
      end
      IMM_S: begin
        legal = sext_fits(imm, 11);
        word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      end
      IMM_B: begin
        // Branch offsets are byte offsets in halfword units; bit 0 is implicit.
        legal = sext_fits(imm, 12) && !imm[0];
        word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      end
      default: begin
        legal = 1'b0;
        word  = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - packs decoded fields into instruction words and streams them to imem
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  imm_encoder_if.slave      bus,
  output logic [ADDR_W:0]   word_count,
  output logic              err,
  output logic [ADDR_W:0]   err_index,
  output logic              full
);

  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'((1 << ADDR_W) - 1);

  state_e      state_q, state_d;
  logic [31:0] pack_word;
  logic        pack_legal;
  logic        xfer;
  logic        accept;

  imm_pack u_pack (
    .src    (bus.in_imm_src),
    .imm    (bus.in_imm),
    .opcode (bus.in_opcode),
    .funct3 (bus.in_funct3),
    .rd     (bus.in_rd),
    .rs1    (bus.in_rs1),
    .rs2    (bus.in_rs2),
    .word   (pack_word),
    .legal  (pack_legal)
  );

  assign bus.in_ready = (state_q == ST_LOAD);
  assign full         = (state_q == ST_FULL);

  // start takes priority: a coincident input is neither written nor flagged.
  assign xfer   = bus.in_valid && bus.in_ready && !start;
  assign accept = xfer && pack_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start)
      state_d = ST_LOAD;
    else if (accept && (word_count == LAST))
      state_d = ST_FULL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count    <= '0;
      err           <= 1'b0;
      err_index     <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 32'h0;
    end else if (start) begin
      word_count <= '0;
      err        <= 1'b0;
      err_index  <= '0;
      bus.mem_we <= 1'b0;
    end else begin
      bus.mem_we <= accept;
      if (accept) begin
        // The write address is simply the number of words already stored.
        bus.mem_addr  <= word_count[ADDR_W-1:0];
        bus.mem_wdata <= pack_word;
        word_count    <= word_count + (ADDR_W+1)'(1);
      end
      if (xfer && !pack_legal) begin
        err <= 1'b1;
        if (!err) err_index <= word_count;
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - self-checking bench for imm_encoder with an RV32 extender model
module tb_imm_encoder;
  import imm_encoder_pkg::*;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [AW:0] word_count;
  logic [AW:0] err_index;
  logic        err;
  logic        full;

  int checks = 0;
  int errors = 0;

  imm_encoder_if #(.ADDR_W(AW)) bus ();

  imm_encoder #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus),
    .word_count (word_count),
    .err        (err),
    .err_index  (err_index),
    .full       (full)
  );

  always #5 clk = ~clk;

  // Immediate as the core's extender would rebuild it from the instruction word.
  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] src);
    case (src)
      2'b00:   return {{20{w[31]}}, w[31:20]};
      2'b01:   return {{20{w[31]}}, w[31:25], w[11:7]};
      default: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endcase
  endfunction

  function automatic bit legal_model(input logic [1:0] src, input int imm);
    case (src)
      2'b00, 2'b01: return (imm >= -2048) && (imm <= 2047);
      2'b10:        return (imm >= -4096) && (imm <= 4095) && ((imm & 1) == 0);
      default:      return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic [1:0] src, input logic [31:0] imm, input logic [6:0] opc,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2);
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.in_imm_src = src;
    bus.in_imm     = imm;
    bus.in_opcode  = opc;
    bus.in_funct3  = f3;
    bus.in_rd      = rd;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mem: got we=%b addr=%0d data=%h want all 0", bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if ({word_count, err, err_index, full, bus.in_ready} !== '0) begin
      errors++;
      $display("FAIL reset_status: got wc=%0d err=%b idx=%0d full=%b rdy=%b want all 0",
               word_count, err, err_index, full, bus.in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: got %b want 0", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    pulse_start();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready: got %b want 1", bus.in_ready);
    end
    drive(2'b00, 32'hFFFF_FFFF, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0);
    @(posedge clk); #1;
    checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, AW'(0), 32'hFFF0_0093}) begin
      errors++;
      $display("FAIL i_word: got we=%b addr=%0d data=%h want 1/0/fff00093", bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if (word_count !== (AW+1)'(1)) begin
      errors++;
      $display("FAIL i_count: got %0d want 1", word_count);
    end
    idle();
    @(posedge clk); #1;
    checks++;
    if (bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL we_pulse: got %b want 0", bus.mem_we);
    end
    drive(2'b01, 32'd8, 7'b0100011, 3'b010, 5'd0, 5'd0, 5'd2);
    @(posedge clk); #1;
    checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, AW'(1), 32'h0020_2423}) begin
      errors++;
      $display("FAIL s_word: got we=%b addr=%0d data=%h want 1/1/00202423", bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    drive(2'b10, 32'hFFFF_FFFC, 7'b1100011, 3'b000, 5'd0, 5'd0, 5'd0);
    @(posedge clk); #1;
    checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, AW'(2), 32'hFE00_0EE3}) begin
      errors++;
      $display("FAIL b_word: got we=%b addr=%0d data=%h want 1/2/fe000ee3", bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    idle();
  endtask

  task automatic test_errors();
    pulse_start();
    drive(2'b00, 32'd5, OP_IMM, 3'd0, 5'd3, 5'd4, 5'd0);
    @(posedge clk); #1;
    checks++;
    if ({bus.mem_we, bus.mem_addr, err} !== {1'b1, AW'(0), 1'b0}) begin
      errors++;
      $display("FAIL err_first_ok: got we=%b addr=%0d err=%b want 1/0/0", bus.mem_we, bus.mem_addr, err);
    end
    drive(2'b10, 32'd3, OP_BRANCH, 3'd0, 5'd0, 5'd1, 5'd2);
    @(posedge clk); #1;
    checks++;
    if ({bus.mem_we, err, err_index, word_count} !== {1'b0, 1'b1, (AW+1)'(1), (AW+1)'(1)}) begin
      errors++;
      $display("FAIL err_b_odd: got we=%b err=%b idx=%0d wc=%0d want 0/1/1/1", bus.mem_we, err, err_index, word_count);
    end
    drive(2'b00, 32'd2048, OP_IMM, 3'd0, 5'd1, 5'd1, 5'd0);
    @(posedge clk); #1;
    checks++;
    if ({bus.mem_we, err, err_index, word_count} !== {1'b0, 1'b1, (AW+1)'(1), (AW+1)'(1)}) begin
      errors++;
      $display("FAIL err_i_range: got we=%b err=%b idx=%0d wc=%0d want 0/1/1/1", bus.mem_we, err, err_index, word_count);
    end
    drive(2'b11, 32'd0, OP_IMM, 3'd0, 5'd1, 5'd1, 5'd0);
    @(posedge clk); #1;
    checks++;
    if ({bus.mem_we, err, err_index, word_count} !== {1'b0, 1'b1, (AW+1)'(1), (AW+1)'(1)}) begin
      errors++;
      $display("FAIL err_src11: got we=%b err=%b idx=%0d wc=%0d want 0/1/1/1", bus.mem_we, err, err_index, word_count);
    end
    drive(2'b01, 32'hFFFF_FFFC, OP_STORE, 3'd2, 5'd0, 5'd5, 5'd6);
    @(posedge clk); #1;
    checks++;
    if ({bus.mem_we, bus.mem_addr, err, word_count} !== {1'b1, AW'(1), 1'b1, (AW+1)'(2)}) begin
      errors++;
      $display("FAIL err_resume: got we=%b addr=%0d err=%b wc=%0d want 1/1/1/2", bus.mem_we, bus.mem_addr, err, word_count);
    end
    idle();
  endtask

  task automatic test_boundaries();
    logic [1:0] bs [12] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01,
                            2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    int         bi [12] = '{2047, -2048, 2048, -2049, 2047, -2049,
                            4094, -4096, 4096, -4098, 2, 1};
    int cnt;
    bit ok;
    pulse_start();
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (cnt == DEPTH) begin
        pulse_start();
        cnt = 0;
      end
      ok = legal_model(bs[k], bi[k]);
      drive(bs[k], bi[k], OP_IMM, 3'd1, 5'd2, 5'd3, 5'd4);
      @(posedge clk); #1;
      checks++;
      if (bus.mem_we !== ok) begin
        errors++;
        $display("FAIL boundary[%0d] src=%0d imm=%0d: got we=%b want %b", k, bs[k], bi[k], bus.mem_we, ok);
      end else if (ok) begin
        checks++;
        if (extend(bus.mem_wdata, bs[k]) !== bi[k]) begin
          errors++;
          $display("FAIL boundary_rt[%0d]: got %h want %h", k, extend(bus.mem_wdata, bs[k]), bi[k]);
        end
      end
      if (ok) cnt++;
    end
    idle();
  endtask

  task automatic test_fill_restart();
    int imm;
    pulse_start();
    for (int k = 0; k < DEPTH; k++) begin
      imm = int'($urandom_range(0, 4095)) - 2048;
      drive(2'b00, imm, OP_IMM, 3'(k), 5'(k + 1), 5'(k + 2), 5'd0);
      @(posedge clk); #1;
      checks++;
      if ({bus.mem_we, bus.mem_addr} !== {1'b1, AW'(k)} || extend(bus.mem_wdata, 2'b00) !== imm) begin
        errors++;
        $display("FAIL fill[%0d]: got we=%b addr=%0d imm=%h want 1/%0d/%h", k, bus.mem_we, bus.mem_addr,
                 extend(bus.mem_wdata, 2'b00), k, imm);
      end
    end
    checks++;
    if ({full, bus.in_ready, word_count} !== {1'b1, 1'b0, (AW+1)'(DEPTH)}) begin
      errors++;
      $display("FAIL full_state: got full=%b rdy=%b wc=%0d want 1/0/%0d", full, bus.in_ready, word_count, DEPTH);
    end
    drive(2'b00, 32'd1, OP_IMM, 3'd0, 5'd1, 5'd1, 5'd0);
    @(posedge clk); #1;
    checks++;
    if ({bus.mem_we, word_count, err} !== {1'b0, (AW+1)'(DEPTH), 1'b0}) begin
      errors++;
      $display("FAIL full_block: got we=%b wc=%0d err=%b want 0/%0d/0", bus.mem_we, word_count, err, DEPTH);
    end
    pulse_start();
    checks++;
    if ({full, bus.in_ready, word_count} !== {1'b0, 1'b1, (AW+1)'(0)}) begin
      errors++;
      $display("FAIL restart: got full=%b rdy=%b wc=%0d want 0/1/0", full, bus.in_ready, word_count);
    end
  endtask

  task automatic test_start_wins();
    pulse_start();
    drive(2'b10, 32'd3, OP_BRANCH, 3'd0, 5'd0, 5'd0, 5'd0);
    drive(2'b00, 32'd7, OP_IMM, 3'd0, 5'd1, 5'd1, 5'd0);
    @(posedge clk); #1;
    drive(2'b00, 32'd9, OP_IMM, 3'd0, 5'd1, 5'd1, 5'd0);
    start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.mem_we, word_count, err, err_index} !== {1'b0, (AW+1)'(0), 1'b0, (AW+1)'(0)}) begin
      errors++;
      $display("FAIL start_wins: got we=%b wc=%0d err=%b idx=%0d want 0/0/0/0", bus.mem_we, word_count, err, err_index);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.mem_we, bus.mem_addr, word_count} !== {1'b1, AW'(0), (AW+1)'(1)} ||
        extend(bus.mem_wdata, 2'b00) !== 32'd9) begin
      errors++;
      $display("FAIL after_start: got we=%b addr=%0d wc=%0d imm=%h want 1/0/1/9", bus.mem_we, bus.mem_addr,
               word_count, extend(bus.mem_wdata, 2'b00));
    end
    idle();
  endtask

  task automatic test_random();
    int         cnt;
    int         midx;
    bit         merr;
    bit         ok;
    int         imm;
    logic [1:0] src;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    logic [31:0] w;
    pulse_start();
    cnt = 0; merr = 0; midx = 0;
    for (int n = 0; n < 150; n++) begin
      if (cnt == DEPTH) begin
        pulse_start();
        cnt = 0; merr = 0; midx = 0;
      end
      src = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0:       imm = int'($urandom);
        1:       imm = int'($urandom_range(0, 8191)) - 4096;
        default: imm = (src == 2'b10) ? ((int'($urandom_range(0, 8191)) - 4096) & ~1)
                                      : int'($urandom_range(0, 4095)) - 2048;
      endcase
      opc = 7'($urandom); f3 = 3'($urandom);
      rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      ok = legal_model(src, imm);
      drive(src, imm, opc, f3, rd, rs1, rs2);
      @(posedge clk); #1;
      w = bus.mem_wdata;
      if (ok) begin
        checks++;
        if ({bus.mem_we, bus.mem_addr} !== {1'b1, AW'(cnt)} || extend(w, src) !== imm) begin
          errors++;
          $display("FAIL rand_rt[%0d] src=%0d: got we=%b addr=%0d imm=%h want 1/%0d/%h", n, src, bus.mem_we,
                   bus.mem_addr, extend(w, src), cnt, imm);
        end
        checks++;
        if ({w[6:0], w[14:12], w[19:15], (src == 2'b00) ? w[11:7] : w[24:20]} !==
            {opc, f3, rs1, (src == 2'b00) ? rd : rs2}) begin
          errors++;
          $display("FAIL rand_fields[%0d]: got %h want opc=%h f3=%h rs1=%h rd/rs2=%h", n, w, opc, f3, rs1,
                   (src == 2'b00) ? rd : rs2);
        end
        cnt++;
      end else begin
        checks++;
        if (bus.mem_we !== 1'b0) begin
          errors++;
          $display("FAIL rand_reject[%0d]: got we=%b want 0", n, bus.mem_we);
        end
        if (!merr) midx = cnt;
        merr = 1'b1;
      end
      checks++;
      if ({word_count, err, err_index, full} !== {(AW+1)'(cnt), merr, (AW+1)'(midx), cnt == DEPTH}) begin
        errors++;
        $display("FAIL rand_status[%0d]: got wc=%0d err=%b idx=%0d full=%b want %0d/%b/%0d/%b", n, word_count,
                 err, err_index, full, cnt, merr, midx, cnt == DEPTH);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    pulse_start();
    drive(2'b11, 32'd0, OP_IMM, 3'd0, 5'd1, 5'd1, 5'd0);
    drive(2'b00, 32'd100, OP_IMM, 3'd0, 5'd1, 5'd1, 5'd0);
    drive(2'b01, 32'd200, OP_STORE, 3'd0, 5'd0, 5'd1, 5'd2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, word_count, err, err_index, full, bus.in_ready} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got we=%b addr=%0d data=%h wc=%0d err=%b idx=%0d full=%b rdy=%b want all 0",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, word_count, err, err_index, full, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.mem_we, word_count, bus.in_ready} !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: got we=%b wc=%0d rdy=%b want 0/0/0", bus.mem_we, word_count, bus.in_ready);
    end
    idle();
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_imm_src = 2'b00;
    bus.in_imm     = 32'h0;
    bus.in_opcode  = 7'h0;
    bus.in_funct3  = 3'h0;
    bus.in_rd      = 5'h0;
    bus.in_rs1     = 5'h0;
    bus.in_rs2     = 5'h0;
    test_reset();
    test_directed();
    test_errors();
    test_boundaries();
    test_fill_restart();
    test_start_wins();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Instruction-word packer for the single-cycle RISC-V core: the inverse of the immediate extender. It accepts decoded fields plus a 32-bit signed immediate and an immediate-format select. It range-checks the immediate, scatters its bits into I/S/B instruction layout, and streams the packed words into instruction memory at consecutive word addresses. It sits between the test/boot loader and the instruction-memory write port.

## Interface
Parameters:
- ADDR_W, 6: instruction-memory word-address width; depth = 2**ADDR_W.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a new load at word address 0
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder can accept this cycle
- in_imm_src  in  2  00 I-type, 01 S-type, 10 B-type, 11 illegal
- in_imm  in  32  signed immediate (B: byte offset)
- in_opcode  in  7  opcode field
- in_funct3  in  3  funct3 field
- in_rd  in  5  rd (I only)
- in_rs1  in  5  rs1
- in_rs2  in  5  rs2 (S/B only)
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  packed instruction
- word_count  out  ADDR_W+1  words written since start
- err  out  1  sticky: at least one input rejected
- err_index  out  ADDR_W+1  value of word_count at first rejection
- full  out  1  memory filled; no further accepts

## Operation
- States: IDLE, LOAD, FULL. Reset and power-up → IDLE.
- IDLE --start--> LOAD. LOAD --write to address 2**ADDR_W-1--> FULL. start in any state → LOAD, clears word_count, err, err_index, and address.
- in_ready = (state==LOAD). A transfer occurs when in_valid && in_ready.
- Range check per transfer:
  - I/S: in_imm[31:11] all equal.
  - B: in_imm[31:12] all equal and in_imm[0]==0.
  - src 11: always rejected.
- Packing:
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- Accepted legal transfer: write the word at the current address, then increment the address and word_count.
- Rejected transfer:
  - No write; address and word_count unchanged.
  - err set. err_index captured only if err was 0.
  - Transfer is still consumed (in_ready not withheld).
- Round-trip invariant: feeding mem_wdata[31:7] and in_imm_src to the extender returns in_imm for every legal transfer.

## Timing
- Outputs are registered. Transfer at edge N → mem_we/mem_addr/mem_wdata valid during cycle N+1; word_count updated at edge N.
- mem_we is high for exactly one cycle per legal transfer.
- Back-to-back transfers sustain one word per cycle.
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, word_count=0, err=0, err_index=0, full=0, in_ready=0.
- full asserts on the edge that accepts the last-address write. in_ready drops in the same cycle full rises.
- start coincident with in_valid: start wins; that input is not accepted. The next cycle accepts normally.
- rst_n asserted mid-load: all state cleared immediately. Any pending mem_we is dropped asynchronously.

## Structure
- Shared package holds:
  - ImmSrc encodings (IMM_I, IMM_S, IMM_B); must match the extender.
  - State enum.
  - Opcode constants used by benches.
- One combinational sub-module, imm_pack: src + immediate + fields in; packed word and legal flag out. Reusable by the assembler bench model.

## Test plan
- Reset, start; I-type opcode 0010011, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF → address 0 written with 0xFFF00093 one cycle later.
- S-type opcode 0100011, funct3=010, rs1=0, rs2=2, imm=8 → 0x00202423.
- B-type opcode 1100011, funct3=000, rs1=rs2=0, imm=0xFFFFFFFC → 0xFE000EE3.
- B imm=3, then I imm=2048, then src=11 → no mem_we; err=1; err_index=word_count at first; next legal word lands at the unchanged address.
- ADDR_W=2, four legal back-to-back words → addresses 0..3, full=1, in_ready=0; start → full=0, word_count=0.
- Randomized legal inputs → extender(mem_wdata[31:7], src) == in_imm. Also: rst_n pulsed mid-stream → all outputs at reset values.
